// File: rtl/sub_bytes_if.sv
// -----------------------------------------------------------------------------
// sub_bytes_if
//
// Purpose : groups the state-in / state-out valid-ready handshakes of
//           sub_bytes_seq into one bundle.
//
// Signals :
//   in_valid   producer -> block   in_state is valid
//   in_ready   block -> producer   block can accept a state
//   in_state   producer -> block   128-bit AES state, byte k = [127-8k -: 8]
//   out_valid  block -> consumer   out_state is valid
//   out_ready  consumer -> block   consumer takes out_state
//   out_state  block -> consumer   substituted state, same byte ordering
//
// Modports:
//   master  the side that supplies states and consumes results
//   slave   the sub_bytes_seq side
// -----------------------------------------------------------------------------
interface sub_bytes_if;

  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;

  modport master (
    output in_valid,
    output in_state,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_state
  );

  modport slave (
    input  in_valid,
    input  in_state,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_state
  );

endinterface : sub_bytes_if

// File: rtl/sub_bytes_seq.sv
// -----------------------------------------------------------------------------
// sub_bytes_seq
//
// Purpose : applies the AES SubBytes transform to a 128-bit state one byte
//           at a time through a shared, externally registered byte S-box.
//           One state is in flight at a time: accept, issue 16 lookups,
//           drain the S-box pipeline, present the result, repeat.
//
// Parameters:
//   SBOX_LAT  cycles from sb_addr presented to sb_data valid (1 or 2)
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   bus       sub_bytes_if.slave - in_valid/in_ready/in_state and
//             out_valid/out_ready/out_state handshakes
//   sb_addr   byte lookup address to the S-box (8'h00 outside ISSUE)
//   sb_data   S-box result, SBOX_LAT cycles after sb_addr
//   busy      high whenever the FSM is not in IDLE
//
// Build option:
//   SUB_BYTES_SHIFT_ROWS_EN  when defined, each looked-up byte is written to
//                            its ShiftRows destination so out_state becomes
//                            ShiftRows(SubBytes(state)); latency unchanged.
//
// Timing (E0 = accepting edge):
//   cycle k (k = 1..16) drives sb_addr = byte k-1
//   byte j is captured at edge E(j+1+SBOX_LAT)
//   out_valid rises at E(16+SBOX_LAT) and holds until out_ready
// -----------------------------------------------------------------------------
module sub_bytes_seq #(
  parameter int SBOX_LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  sub_bytes_if.slave   bus,
  output logic [7:0]   sb_addr,
  input  logic [7:0]   sb_data,
  output logic         busy
);

  // ---------------------------------------------------------------------------
  // FSM encoding
  // ---------------------------------------------------------------------------
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]         state_q;
  logic [1:0]         state_d;

  // Index of the byte being issued in ISSUE.
  logic [3:0]         idx_q;

  // Latched input and accumulated result, one element per state byte.
  // Element [15-k] holds byte k so that packing back to 128 bits keeps
  // byte 0 in the most significant position.
  logic [15:0][7:0]   in_buf_q;
  logic [15:0][7:0]   res_q;

  // Lookup-in-flight tracker: stage i is valid/index for a lookup issued
  // i+1 cycles ago; the last stage lines up with sb_data.
  logic [SBOX_LAT-1:0] pipe_vld_q;
  logic [3:0]          pipe_idx_q [SBOX_LAT];

  logic               accept;
  logic               issue;
  logic               capture;
  logic               last_capture;
  logic [3:0]         cap_idx;
  logic [3:0]         wr_pos;

  // ---------------------------------------------------------------------------
  // Handshake and status decode
  // ---------------------------------------------------------------------------
  // in_ready is also gated by rst_n so that nothing is offered while the
  // block is held in reset.
  assign bus.in_ready  = (state_q == IDLE) && rst_n;
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_state = res_q;
  assign busy          = (state_q != IDLE);

  assign accept        = bus.in_valid && bus.in_ready;
  assign issue         = (state_q == ISSUE);

  assign capture       = pipe_vld_q[SBOX_LAT-1];
  assign cap_idx       = pipe_idx_q[SBOX_LAT-1];
  assign last_capture  = capture && (cap_idx == 4'd15);

  // Address is forced to zero outside ISSUE so the S-box sees a quiet bus.
  assign sb_addr       = issue ? in_buf_q[4'd15 - idx_q] : 8'h00;

  // ---------------------------------------------------------------------------
  // Result write position
  // ---------------------------------------------------------------------------
`ifdef SUB_BYTES_SHIFT_ROWS_EN
  // ShiftRows moves source byte (row r, col c) to column (c - r) mod 4 of
  // the same row. The 2-bit subtraction wraps, giving the mod 4 for free.
  logic [1:0] cap_row;
  logic [1:0] cap_col;
  logic [1:0] dst_col;

  assign cap_row = cap_idx[1:0];
  assign cap_col = cap_idx[3:2];
  assign dst_col = cap_col - cap_row;
  assign wr_pos  = {dst_col, cap_row};
`else
  assign wr_pos  = cap_idx;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: assigning a default first means every path drives state_d, so no
    // latch is inferred even when no case arm changes it.
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)            state_d = ISSUE;
      ISSUE:   if (idx_q == 4'd15)    state_d = DRAIN;
      DRAIN:   if (last_capture)      state_d = DONE;
      DONE:    if (bus.out_ready)     state_d = IDLE;
      default:                        state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control state: FSM, issue index, lookup tracker
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignment so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= 4'd0;
      pipe_vld_q <= '0;
      for (int i = 0; i < SBOX_LAT; i++) begin
        pipe_idx_q[i] <= 4'd0;
      end
    end else begin
      state_q <= state_d;

      if (accept) begin
        idx_q <= 4'd0;
      end else if (issue) begin
        idx_q <= idx_q + 4'd1;
      end

      pipe_vld_q[0] <= issue;
      pipe_idx_q[0] <= idx_q;
      for (int i = 1; i < SBOX_LAT; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_idx_q[i] <= pipe_idx_q[i-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Result register
  // ---------------------------------------------------------------------------
  // Cleared on reset so out_state reads zero until the first result lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
    end else if (capture) begin
      res_q[4'd15 - wr_pos] <= sb_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Input buffer
  // ---------------------------------------------------------------------------
  // NOTE: pure datapath storage with no reset; it is only read in ISSUE,
  // which is always preceded by a load on accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      in_buf_q <= bus.in_state;
    end
  end

endmodule : sub_bytes_seq

// File: tb/tb_sub_bytes_seq.sv
// -----------------------------------------------------------------------------
// tb_sub_bytes_seq
//
// Directed bench for sub_bytes_seq. dut1 uses SBOX_LAT=1 and dut2 uses
// SBOX_LAT=2, each fed by a behavioural registered S-box of matching depth.
// Expected results are hand-computed constants; the ShiftRows variants are
// selected when SUB_BYTES_SHIFT_ROWS_EN is defined for the build.
// -----------------------------------------------------------------------------
module tb_sub_bytes_seq;

  logic       clk;
  logic       rst_n;
  logic [7:0] sb_addr1, sb_data1, busy_unused1;
  logic [7:0] sb_addr2, sb_data2, sb_mid2;
  logic       busy1, busy2;

  int n_cmp = 0;
  int n_err = 0;

  sub_bytes_if bus1 ();
  sub_bytes_if bus2 ();

  sub_bytes_seq #(.SBOX_LAT(1)) dut1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus1.slave),
    .sb_addr (sb_addr1),
    .sb_data (sb_data1),
    .busy    (busy1)
  );

  sub_bytes_seq #(.SBOX_LAT(2)) dut2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus2.slave),
    .sb_addr (sb_addr2),
    .sb_data (sb_data2),
    .busy    (busy2)
  );

  // AES forward S-box, entry a at index a.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [127:0] VEC_A  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] VEC_B  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] VEC_F  = 128'hffffffffffffffffffffffffffffffff;
  localparam logic [127:0] EXP_0  = 128'h63636363636363636363636363636363;
`ifdef SUB_BYTES_SHIFT_ROWS_EN
  localparam logic [127:0] EXP_A  = 128'h63fcac161bee28c3c4c193f54b8233ea;
  localparam logic [127:0] EXP_B  = 128'h636b6776f201ab7b30d777c5fe7c6f2b;
`else
  localparam logic [127:0] EXP_A  = 128'h638293c31bfc33f5c4eeacea4bc12816;
  localparam logic [127:0] EXP_B  = 128'h637c777bf26b6fc53001672bfed7ab76;
`endif

  // Registered S-box models: one stage for dut1, two stages for dut2.
  always @(posedge clk) begin
    sb_data1 <= SBOX[sb_addr1];
    sb_mid2  <= SBOX[sb_addr2];
    sb_data2 <= sb_mid2;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transaction on dut1 with cycle-exact checks. stall = number of
  // out_valid cycles with out_ready low; in_valid is pulsed during the stall.
  task automatic run1(input logic [127:0] vec, input logic [127:0] exp,
                      input int stall, input string tag);
    logic [7:0] b;
    @(negedge clk);
    bus1.in_valid  = 1'b1;
    bus1.in_state  = vec;
    bus1.out_ready = (stall == 0);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      bus1.in_valid = 1'b0;
      b = vec[127 - 8*(k-1) -: 8];
      check({tag, "_sb_addr"}, sb_addr1, b);
      check({tag, "_no_early_valid"}, bus1.out_valid, 0);
      if (k == 1) begin
        check({tag, "_in_ready_low"}, bus1.in_ready, 0);
        check({tag, "_busy_high"}, busy1, 1);
      end
    end
    @(negedge clk);  // cycle 17
    check({tag, "_c17_out_valid"}, bus1.out_valid, 0);
    check({tag, "_c17_sb_addr"}, sb_addr1, 0);
    @(negedge clk);  // cycle 18, after E17
    check({tag, "_out_valid"}, bus1.out_valid, 1);
    check({tag, "_out_state"}, bus1.out_state, exp);
    for (int s = 0; s < stall; s++) begin
      bus1.in_valid = s[0];
      bus1.in_state = ~vec;
      @(negedge clk);
      check({tag, "_hold_valid"}, bus1.out_valid, 1);
      check({tag, "_hold_state"}, bus1.out_state, exp);
      check({tag, "_hold_in_ready"}, bus1.in_ready, 0);
    end
    bus1.in_valid  = 1'b0;
    bus1.out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_idle_in_ready"}, bus1.in_ready, 1);
    check({tag, "_idle_out_valid"}, bus1.out_valid, 0);
    check({tag, "_idle_busy"}, busy1, 0);
  endtask

  initial begin
    int seen;
    int t_ov1, t_ov2, t_acc2;
    logic [127:0] got_a, got_b;

    rst_n          = 1'b0;
    bus1.in_valid  = 1'b0;
    bus1.in_state  = '0;
    bus1.out_ready = 1'b0;
    bus2.in_valid  = 1'b0;
    bus2.in_state  = '0;
    bus2.out_ready = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_in_ready", bus1.in_ready, 0);
    check("rst_out_valid", bus1.out_valid, 0);
    check("rst_busy", busy1, 0);
    check("rst_out_state", bus1.out_state, 0);
    check("rst_sb_addr", sb_addr1, 0);
    check("rst2_in_ready", bus2.in_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", bus1.in_ready, 1);
    check("post_rst2_in_ready", bus2.in_ready, 1);

    // Directed transactions on dut1
    run1(VEC_A, EXP_A, 0, "vec_a");
    run1('0, EXP_0, 0, "zero");
    run1(VEC_B, EXP_B, 5, "backpressure");

    // Reset during ISSUE cycle 8
    @(negedge clk);
    bus1.in_valid = 1'b1;
    bus1.in_state = VEC_F;
    @(negedge clk);
    bus1.in_valid = 1'b0;
    repeat (7) @(negedge clk);
    check("mid_rst_busy_before", busy1, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", bus1.out_valid, 0);
    check("mid_rst_busy", busy1, 0);
    check("mid_rst_in_ready", bus1.in_ready, 0);
    check("mid_rst_sb_addr", sb_addr1, 0);
    check("mid_rst_out_state", bus1.out_state, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus1.out_valid) seen++;
    end
    check("mid_rst_no_stale_valid", seen, 0);
    run1(VEC_A, EXP_A, 0, "after_rst");

    // SBOX_LAT=2, back-to-back inputs on dut2
    t_ov1  = -1;
    t_ov2  = -1;
    t_acc2 = -1;
    got_a  = '0;
    got_b  = '0;
    @(negedge clk);  // cycle 0: accept at E0
    bus2.in_valid  = 1'b1;
    bus2.in_state  = VEC_A;
    bus2.out_ready = 1'b1;
    for (int t = 1; t <= 60; t++) begin
      @(negedge clk);
      if (t == 1) bus2.in_state = VEC_B;
      if (t_acc2 >= 0) bus2.in_valid = 1'b0;
      if (bus2.out_valid && t_ov1 < 0) begin
        t_ov1 = t;
        got_a = bus2.out_state;
      end else if (bus2.out_valid && t_ov2 < 0 && t_ov1 >= 0) begin
        t_ov2 = t;
        got_b = bus2.out_state;
      end
      if (bus2.in_ready && bus2.in_valid && t_acc2 < 0) t_acc2 = t;
    end
    check("lat2_first_valid_cycle", t_ov1, 19);
    check("lat2_first_state", got_a, EXP_A);
    check("lat2_second_accept_cycle", t_acc2, 20);
    check("lat2_second_valid_cycle", t_ov2, 39);
    check("lat2_second_state", got_b, EXP_B);
    check("lat2_final_in_ready", bus2.in_ready, 1);
    check("lat2_final_busy", busy2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_sub_bytes_seq

// File: doc/sub_bytes_seq.md
SUB_BYTES_SEQ -- requirements
Module: sub_bytes_seq

Interface
REQ-001 SHALL have parameter: SBOX_LAT, default 1, cycles from sb_addr presented to sb_data valid; legal values 1 or 2.
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: in_valid  input  1  in_state valid.
REQ-005 SHALL have port: in_ready  output  1  block can accept a state.
REQ-006 SHALL have port: in_state  input  128  AES state; byte k = in_state[127-8k -: 8], column-major (byte 4c+r = row r, col c).
REQ-007 SHALL have port: sb_addr  output  8  byte lookup address to the registered byte S-box.
REQ-008 SHALL have port: sb_data  input  8  S-box result, SBOX_LAT cycles after sb_addr.
REQ-009 SHALL have port: out_valid  output  1  out_state valid.
REQ-010 SHALL have port: out_ready  input  1  downstream accepts out_state.
REQ-011 SHALL have port: out_state  output  128  substituted state, same byte ordering.
REQ-012 SHALL have port: busy  output  1  high in any state other than IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, ISSUE, DRAIN, DONE.
REQ-014 IDLE: in_ready=1; on in_valid&in_ready at edge E0 SHALL latch in_state, clear index, go to ISSUE.
REQ-015 ISSUE: in cycle k (k=1..16 after E0) SHALL drive sb_addr = byte k-1 of latched state; after byte 15 go to DRAIN.
REQ-016 SHALL capture sb_data into result byte j at the edge SBOX_LAT cycles after byte j was issued, using a SBOX_LAT-deep valid/index pipeline.
REQ-017 DRAIN: SHALL wait until byte 15 captured, then go to DONE; out_valid SHALL assert at edge E(16+SBOX_LAT) (E17 for default).
REQ-018 DONE: out_valid=1 and out_state SHALL hold stable until out_valid&out_ready, then go to IDLE.
REQ-019 in_ready SHALL be 0 in ISSUE, DRAIN and DONE; no overlap of two states in flight; in_valid ignored outside IDLE.
REQ-020 out_ready SHALL be ignored when out_valid=0; out_ready held high in advance SHALL complete handshake on the first out_valid cycle.
REQ-021 sb_addr SHALL be 8'h00 outside ISSUE.
REQ-022 After output handshake, in_ready SHALL be 1 in the next cycle; minimum accept-to-accept spacing 18+SBOX_LAT cycles.

Reset
REQ-023 rst_n low SHALL immediately force IDLE, in_ready=1 only after release (in_ready low while rst_n low), out_valid=0, busy=0, out_state=0, sb_addr=0, index and pipeline valids cleared.
REQ-024 Reset asserted mid-ISSUE or mid-DONE SHALL discard the in-flight state; no out_valid for it after release.

Configuration
REQ-025 Macro SUB_BYTES_SHIFT_ROWS_EN: when defined, out_state SHALL be ShiftRows(SubBytes(state)), i.e. out byte 4c+r = sub byte 4((c+r) mod 4)+r, applied combinationally on register write, latency unchanged.
REQ-026 Without SUB_BYTES_SHIFT_ROWS_EN, out_state SHALL be SubBytes(state) only, with no ShiftRows logic present.

Verification
REQ-027 in_state=00112233445566778899aabbccddeeff, macro off, out_ready=1 -> out_state=638293c31bfc33f5c4eeacea4bc12816, out_valid at E17.
REQ-028 Same input, macro on -> out_state=63fcac161bee28c3c4c193f54b8233ea.
REQ-029 in_state=0 -> out_state=6363...63 (16 bytes); sb_addr sequence cycles 1..16 all 8'h00.
REQ-030 Backpressure: out_ready=0 for 5 cycles after out_valid -> out_state/out_valid stable, in_ready=0 throughout, in_valid pulses ignored; release -> IDLE next cycle.
REQ-031 rst_n pulsed low during ISSUE cycle 8 -> out_valid=0, busy=0 immediately; new input after release processed correctly, no stale bytes.
REQ-032 SBOX_LAT=2 with a 2-stage delayed model, back-to-back inputs -> correct results, out_valid at E18, second accept exactly one cycle after first output handshake.
